ddc_tune_sequencer: RTL



---
 rtl/ddc_tune_pkg.sv | 14 +
 rtl/ddc_tune_sequencer_if.sv | 21 ++
 rtl/ddc_tune_table.sv | 30 +++
 rtl/ddc_tune_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ddc_tune_pkg.sv
// Shared types for the DDC tuning sequencer: FSM state encoding and phase increment type.
package ddc_tune_pkg;

  localparam int PHASE_WIDTH = 32;

  typedef logic [PHASE_WIDTH-1:0] phase_inc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/ddc_tune_sequencer_if.sv
// Manual retune handshake and NCO phase-increment load bundle.
interface ddc_tune_sequencer_if;
  import ddc_tune_pkg::*;

  phase_inc_t i_man_phase_inc;
  logic       i_man_valid;
  logic       o_man_ready;
  phase_inc_t o_phase_inc;
  logic       o_phase_inc_valid;

  modport master (
    output i_man_phase_inc, i_man_valid,
    input  o_man_ready, o_phase_inc, o_phase_inc_valid
  );

  modport slave (
    input  i_man_phase_inc, i_man_valid,
    output o_man_ready, o_phase_inc, o_phase_inc_valid
  );

endinterface

// File: rtl/ddc_tune_table.sv
// Hop table: DEPTH x 32 register file, synchronous write, asynchronous read, cleared on reset.
module ddc_tune_table
  import ddc_tune_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [AW-1:0] i_wr_addr,
  input  phase_inc_t    i_wr_data,
  input  logic          i_wr_valid,
  input  logic [AW-1:0] i_rd_addr,
  output phase_inc_t    o_rd_data
);

  phase_inc_t r_mem [DEPTH];

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_valid) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // A write landing on the entry being issued this cycle is seen on the next issue.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ddc_tune_sequencer.sv
// DDC tuning controller: arbitrates manual retunes against a dwell-timed frequency-hop table.
// Optional post-retune blanking is built only when DDC_TUNE_BLANK_EN is defined.
module ddc_tune_sequencer
  import ddc_tune_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int DWELL_WIDTH   = 16,
  parameter int BLANK_SAMPLES = 4,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [AW-1:0]          i_tbl_wr_addr,
  input  phase_inc_t             i_tbl_wr_data,
  input  logic                   i_tbl_wr_valid,
  input  logic [AW-1:0]          i_last_index,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_sample_valid,
  ddc_tune_sequencer_if.slave    bus,
  output logic [AW-1:0]          o_hop_index,
  output logic                   o_busy,
  output logic                   o_blank
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic [DWELL_WIDTH-1:0] w_cnt_next;
  logic [DWELL_WIDTH-1:0] w_dwell_m1;
  logic [AW-1:0]          r_idx;
  logic [AW-1:0]          w_issue_idx;
  logic [AW-1:0]          w_wrap_idx;
  logic                   w_issue;
  logic                   w_man_fire;
  phase_inc_t             r_phase_inc;
  logic                   r_phase_vld;
  phase_inc_t             w_tbl_rd;

  ddc_tune_table #(.DEPTH(DEPTH), .AW(AW)) u_table (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_wr_addr  (i_tbl_wr_addr),
    .i_wr_data  (i_tbl_wr_data),
    .i_wr_valid (i_tbl_wr_valid),
    .i_rd_addr  (w_issue_idx),
    .o_rd_data  (w_tbl_rd)
  );

  assign w_dwell_m1 = (i_dwell == '0) ? '0 : i_dwell - DWELL_WIDTH'(1);
  // Wrap also covers an index left beyond a newly shortened table.
  assign w_wrap_idx = (r_idx >= i_last_index) ? '0 : r_idx + AW'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_issue      = 1'b0;
    w_issue_idx  = r_idx;
    w_man_fire   = 1'b0;
    case (r_state)
      IDLE: begin
        w_man_fire = bus.i_man_valid;
        if (i_start && !i_stop) w_state_next = ARM;
      end
      ARM: begin
        if (i_stop) begin
          w_state_next = IDLE;
        end else if (i_sample_valid) begin
          w_state_next = RUN;
          w_issue      = 1'b1;
          w_issue_idx  = '0;
          w_cnt_next   = '0;
        end
      end
      RUN: begin
        if (i_stop) begin
          w_state_next = IDLE;
        end else if (i_sample_valid) begin
          // >= keeps the hop bounded if the dwell is shortened mid-hop.
          if (r_cnt >= w_dwell_m1) begin
            w_cnt_next  = '0;
            w_issue     = 1'b1;
            w_issue_idx = w_wrap_idx;
          end else begin
            w_cnt_next = r_cnt + DWELL_WIDTH'(1);
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_phase_inc <= '0;
      r_phase_vld <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_next;
      r_phase_vld <= w_issue | w_man_fire;
      if (w_issue) begin
        r_idx       <= w_issue_idx;
        r_phase_inc <= w_tbl_rd;
      end else if (w_man_fire) begin
        r_phase_inc <= bus.i_man_phase_inc;
      end
    end
  end

  assign bus.o_man_ready       = (r_state == IDLE) && !i_reset;
  assign bus.o_phase_inc       = r_phase_inc;
  assign bus.o_phase_inc_valid = r_phase_vld;
  assign o_hop_index           = r_idx;
  assign o_busy                = (r_state != IDLE);

`ifdef DDC_TUNE_BLANK_EN
  localparam int BW = $clog2(BLANK_SAMPLES + 1);

  logic [BW-1:0] r_blank_cnt;

  // Loads alongside the pulse so o_blank rises with it, then counts strobes down.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_blank_cnt <= '0;
    end else if (w_issue || w_man_fire) begin
      r_blank_cnt <= BW'(BLANK_SAMPLES);
    end else if (i_sample_valid && r_blank_cnt != '0) begin
      r_blank_cnt <= r_blank_cnt - BW'(1);
    end
  end

  assign o_blank = (r_blank_cnt != '0);
`else
  assign o_blank = 1'b0;
`endif

endmodule
